// File: rtl/irq_timer_ctrl.sv
// Interrupt and timer unit for CP0: synchronises external request lines,
// latches level/edge requests, applies a mask, and runs a COUNT/COMPARE timer
// behind a small memory-mapped register file.
module irq_timer_ctrl #(
  parameter int unsigned          NUM_IRQ     = 6,
  parameter int unsigned          TIMER_W     = 32,
  parameter logic [NUM_IRQ-1:0]   EDGE_SEL    = '0,
  parameter int unsigned          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               we,
  input  logic               re,
  input  logic [2:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic [NUM_IRQ-1:0] intr,
  output logic               timer_int,
  output logic               irq_any,
  output logic [4:0]         irq_id
);

  localparam int unsigned SRC_W = NUM_IRQ + 1;

  localparam logic [2:0] ADDR_PEND = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd1;
  localparam logic [2:0] ADDR_CNT  = 3'd2;
  localparam logic [2:0] ADDR_CMP  = 3'd3;
  localparam logic [2:0] ADDR_CTRL = 3'd4;
  localparam logic [2:0] ADDR_ID   = 3'd5;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] hist_q;
  logic [NUM_IRQ-1:0] sync_last;
  logic [NUM_IRQ-1:0] edge_det;

  logic [SRC_W-1:0]   pend_q, pend_d;
  logic [SRC_W-1:0]   mask_q, mask_d;
  logic [TIMER_W-1:0] count_q, count_d;
  logic [TIMER_W-1:0] compare_q, compare_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               wr_pend, wr_mask, wr_cnt, wr_cmp, wr_ctrl;
  logic [SRC_W-1:0]   w1c;
  logic               timer_en, auto_reload, match;
  logic [SRC_W-1:0]   active;
  logic               id_valid;
  logic [4:0]         id_c;

  assign sync_last   = sync_q[SYNC_STAGES-1];
  assign edge_det    = sync_last & ~hist_q;
  assign timer_en    = ctrl_q[0];
  assign auto_reload = ctrl_q[1];
  assign match       = timer_en && (count_q == compare_q);

  assign wr_pend = we && (addr == ADDR_PEND);
  assign wr_mask = we && (addr == ADDR_MASK);
  assign wr_cnt  = we && (addr == ADDR_CNT);
  assign wr_cmp  = we && (addr == ADDR_CMP);
  assign wr_ctrl = we && (addr == ADDR_CTRL);
  assign w1c     = wr_pend ? wdata[SRC_W-1:0] : '0;

  assign intr      = pend_q[NUM_IRQ-1:0] & mask_q[NUM_IRQ-1:0];
  assign timer_int = pend_q[NUM_IRQ] & mask_q[NUM_IRQ];
  assign active    = {timer_int, intr};
  assign irq_any   = |active;
  assign irq_id    = id_c;
  assign rdata     = rdata_q;

  // Lowest active index wins; timer sits at index NUM_IRQ (lowest priority).
  always_comb begin
    id_c     = 5'd0;
    id_valid = 1'b0;
    for (int i = 0; i < int'(SRC_W); i++) begin
      if (active[i] && !id_valid) begin
        id_c     = 5'(i);
        id_valid = 1'b1;
      end
    end
  end

  // Next-state for pending, mask, timer and control registers.
  always_comb begin
    pend_d    = pend_q;
    mask_d    = mask_q;
    count_d   = count_q;
    compare_d = compare_q;
    ctrl_d    = ctrl_q;

    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (EDGE_SEL[i]) begin
        // A new edge in the same cycle as W1C must not be lost.
        pend_d[i] = (pend_q[i] & ~w1c[i]) | edge_det[i];
      end else begin
        pend_d[i] = sync_last[i];
      end
    end

    pend_d[NUM_IRQ] = (pend_q[NUM_IRQ] & ~w1c[NUM_IRQ]) | match;
    if (wr_cmp) begin
      pend_d[NUM_IRQ] = 1'b0;
    end

    if (timer_en) begin
      count_d = (match && auto_reload) ? '0 : count_q + TIMER_W'(1);
    end
    if (wr_cnt)  count_d   = wdata[TIMER_W-1:0];
    if (wr_cmp)  compare_d = wdata[TIMER_W-1:0];
    if (wr_mask) mask_d    = wdata[SRC_W-1:0];
    if (wr_ctrl) ctrl_d    = wdata[1:0];
  end

  // Read mux sampled on re; registers are read before this cycle's write lands.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      case (addr)
        ADDR_PEND: rdata_d = 32'(pend_q);
        ADDR_MASK: rdata_d = 32'(mask_q);
        ADDR_CNT:  rdata_d = 32'(count_q);
        ADDR_CMP:  rdata_d = 32'(compare_q);
        ADDR_CTRL: rdata_d = 32'(ctrl_q);
        ADDR_ID:   rdata_d = {id_valid, 26'd0, id_c};
        default:   rdata_d = 32'd0;
      endcase
    end
  end

  // Input synchroniser chain plus edge-history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_last;
    end
  end

  // Register file state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      mask_q    <= '0;
      count_q   <= '0;
      compare_q <= '1;
      ctrl_q    <= '0;
      rdata_q   <= '0;
    end else begin
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ctrl_q    <= ctrl_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed bench for irq_timer_ctrl: one 32-bit-timer instance with line 1
// edge-latched, plus a 4-bit-timer instance on the same bus for wrap checks.
module tb_irq_timer_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  irq_in;
  logic        we, re;
  logic [2:0]  addr;
  logic [31:0] wdata;

  logic [31:0] rdata,  rdata4;
  logic [5:0]  intr,   intr4;
  logic        timer_int, timer_int4;
  logic        irq_any,   irq_any4;
  logic [4:0]  irq_id,    irq_id4;

  int n_chk  = 0;
  int n_fail = 0;

  irq_timer_ctrl #(
    .NUM_IRQ(6), .TIMER_W(32), .EDGE_SEL(6'b000010), .SYNC_STAGES(2)
  ) u_dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .intr(intr), .timer_int(timer_int),
    .irq_any(irq_any), .irq_id(irq_id)
  );

  irq_timer_ctrl #(
    .NUM_IRQ(6), .TIMER_W(4), .EDGE_SEL(6'b000010), .SYNC_STAGES(2)
  ) u_dut4 (
    .clk(clk), .rst(rst), .irq_in(irq_in), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata4), .intr(intr4), .timer_int(timer_int4),
    .irq_any(irq_any4), .irq_id(irq_id4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    re = 1'b1; addr = a;
    tick();
    re = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; irq_in = 6'h3F; we = 1'b0; re = 1'b0; addr = 3'd0; wdata = 32'd0;

    // Reset with all request lines high
    tick();
    chk("rst_intr",  32'(intr), 32'h0);
    chk("rst_tint",  32'(timer_int), 32'h0);
    chk("rst_any",   32'(irq_any), 32'h0);
    chk("rst_id",    32'(irq_id), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0; irq_in = 6'h00;
    rd(3'd3);
    chk("rst_compare", rdata, 32'hFFFF_FFFF);

    // Level line 0: three-cycle latency in and out
    wr(3'd1, 32'h01);
    irq_in = 6'h01;
    ticks(2);
    chk("lvl_rise_early", 32'(intr), 32'h00);
    tick();
    chk("lvl_rise", 32'(intr), 32'h01);
    chk("lvl_any",  32'(irq_any), 32'h1);
    irq_in = 6'h00;
    ticks(2);
    chk("lvl_fall_early", 32'(intr), 32'h01);
    tick();
    chk("lvl_fall", 32'(intr), 32'h00);

    // Edge line 1: sticky pending, W1C, set beats W1C
    irq_in = 6'h02; tick(); irq_in = 6'h00;
    ticks(4);
    rd(3'd0);
    chk("edge_sticky", rdata, 32'h02);
    wr(3'd0, 32'h02);
    rd(3'd0);
    chk("edge_w1c", rdata, 32'h00);
    irq_in = 6'h02; tick(); irq_in = 6'h00; tick();
    wr(3'd0, 32'h02);
    rd(3'd0);
    chk("edge_set_wins", rdata, 32'h02);
    wr(3'd0, 32'h02);
    rd(3'd0);
    chk("edge_w1c2", rdata, 32'h00);

    // W1C has no effect on a level line
    irq_in = 6'h01; ticks(4);
    wr(3'd0, 32'h01);
    rd(3'd0);
    chk("lvl_w1c_ignored", rdata, 32'h01);
    irq_in = 6'h00; ticks(4);

    // Timer with auto-reload
    wr(3'd1, 32'h40);
    wr(3'd3, 32'd5);
    wr(3'd2, 32'd0);
    wr(3'd4, 32'h3);
    ticks(5);
    chk("tmr_before", 32'(timer_int), 32'h0);
    tick();
    chk("tmr_hit",   32'(timer_int), 32'h1);
    chk("tmr_id",    32'(irq_id), 32'd6);
    rd(3'd2);
    chk("tmr_reload", rdata, 32'd0);
    wr(3'd3, 32'd100);
    chk("tmr_cmp_clear", 32'(timer_int), 32'h0);
    wr(3'd2, 32'd7);
    rd(3'd2);
    chk("tmr_cnt_write", rdata, 32'd7);
    wr(3'd4, 32'h0);

    // Priority: timer plus lines 2 and 4
    wr(3'd2, 32'h20);
    wr(3'd3, 32'h20);
    wr(3'd4, 32'h1);
    wr(3'd4, 32'h0);
    chk("prio_tmr", 32'(timer_int), 32'h1);
    wr(3'd1, 32'h7F);
    irq_in = 6'b010100; ticks(3);
    chk("prio_intr", 32'(intr), 32'h14);
    chk("prio_id2",  32'(irq_id), 32'd2);
    rd(3'd5);
    chk("prio_idreg", rdata, 32'h8000_0002);
    irq_in = 6'b010000; ticks(3);
    chk("prio_id4", 32'(irq_id), 32'd4);
    irq_in = 6'b000000; ticks(3);
    chk("prio_id6", 32'(irq_id), 32'd6);
    wr(3'd0, 32'h40);
    chk("tmr_w1c",   32'(timer_int), 32'h0);
    chk("none_any",  32'(irq_any), 32'h0);
    chk("none_id",   32'(irq_id), 32'h0);
    rd(3'd5);
    chk("none_idreg", rdata, 32'h0);

    // Read-during-write, rdata hold, reserved addresses, disabled COUNT hold
    we = 1'b1; re = 1'b1; addr = 3'd1; wdata = 32'h05;
    tick();
    we = 1'b0; re = 1'b0;
    chk("rdw_old", rdata, 32'h7F);
    tick();
    chk("rdata_hold", rdata, 32'h7F);
    rd(3'd1);
    chk("mask_new", rdata, 32'h05);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7);
    chk("rsvd7", rdata, 32'h0);
    rd(3'd6);
    chk("rsvd6", rdata, 32'h0);
    rd(3'd2);
    chk("cnt_hold", rdata, 32'h21);

    // Reset mid-operation drops pending state
    irq_in = 6'h01; ticks(3);
    chk("pre_rst_intr", 32'(intr), 32'h01);
    rst = 1'b1; tick();
    chk("mid_rst_intr", 32'(intr), 32'h00);
    chk("mid_rst_any",  32'(irq_any), 32'h0);
    rst = 1'b0; irq_in = 6'h00;

    // 4-bit timer wrap
    wr(3'd3, 32'd3);
    wr(3'd2, 32'd15);
    wr(3'd1, 32'h40);
    wr(3'd4, 32'h1);
    tick();
    rd(3'd2);
    chk("wrap_cnt0",  rdata4, 32'd0);
    chk("wrap_nomatch", 32'(timer_int4), 32'h0);
    wr(3'd4, 32'h0);
    wr(3'd3, 32'd15);
    wr(3'd2, 32'd15);
    wr(3'd4, 32'h1);
    tick();
    chk("wrap_match", 32'(timer_int4), 32'h1);
    rd(3'd2);
    chk("wrap_cnt_after", rdata4, 32'd0);
    wr(3'd2, 32'd7);
    rd(3'd2);
    chk("wrap_cnt_write", rdata4, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
